// File: rtl/operand_entry_if.sv
// Operand-entry pins: raw switches/button in, registered operand bits and status out.
// The design drives the outputs; the board (or bench) drives the raw inputs.
interface operand_entry_if;
    logic sw0;
    logic sw1;
    logic sw2;
    logic btn;
    logic x0;
    logic x1;
    logic x2;
    logic y0;
    logic y1;
    logic y2;
    logic valid;
    logic led_ld_x;
    logic led_ld_y;

    modport slave (
        input  sw0, sw1, sw2, btn,
        output x0, x1, x2, y0, y1, y2, valid, led_ld_x, led_ld_y
    );

    modport master (
        output sw0, sw1, sw2, btn,
        input  x0, x1, x2, y0, y1, y2, valid, led_ld_x, led_ld_y
    );
endinterface

// File: rtl/operand_entry.sv
// Synchronise/debounce switches and button, capture X then Y on successive presses.
// Capture lands DEBOUNCE_CYCLES+3 edges after the button is first sampled high; no backpressure.
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    operand_entry_if.slave io
);

    typedef enum logic [1:0] {
        S_LOAD_X = 2'd0,
        S_LOAD_Y = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_meta_q, btn_sync_q;
    logic [2:0]       sw_meta_q, sw_sync_q;
    logic             db_q, db_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press;
    state_t           state_q;
    logic [2:0]       x_q, y_q;
    logic             valid_q;

    // Two-flop synchronisers; switches are only sampled at press edges so need no debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            sw_meta_q  <= 3'b000;
            sw_sync_q  <= 3'b000;
        end else begin
            btn_meta_q <= io.btn;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= {io.sw2, io.sw1, io.sw0};
            sw_sync_q  <= sw_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            db_prev_q <= db_q;
            if (btn_sync_q == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                db_q  <= btn_sync_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press = db_q & ~db_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD_X;
            x_q     <= 3'b000;
            y_q     <= 3'b000;
            valid_q <= 1'b0;
        end else if (press) begin
            case (state_q)
                S_LOAD_X: begin
                    x_q     <= sw_sync_q;
                    state_q <= S_LOAD_Y;
                end
                S_LOAD_Y: begin
                    y_q     <= sw_sync_q;
                    valid_q <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    // S_DONE and the unused encoding both clear and restart entry.
                    x_q     <= 3'b000;
                    y_q     <= 3'b000;
                    valid_q <= 1'b0;
                    state_q <= S_LOAD_X;
                end
            endcase
        end
    end

    assign io.x0       = x_q[0];
    assign io.x1       = x_q[1];
    assign io.x2       = x_q[2];
    assign io.y0       = y_q[0];
    assign io.y1       = y_q[1];
    assign io.y2       = y_q[2];
    assign io.valid    = valid_q;
    assign io.led_ld_x = (state_q == S_LOAD_X);
    assign io.led_ld_y = (state_q == S_LOAD_Y);

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a short debounce window (4 cycles, capture 7 edges after first high sample).
module tb_operand_entry;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    operand_entry_if intf ();

    operand_entry #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] xv();
        return {intf.x2, intf.x1, intf.x0};
    endfunction

    function automatic logic [2:0] yv();
        return {intf.y2, intf.y1, intf.y0};
    endfunction

    // {valid, led_ld_y, led_ld_x}
    function automatic logic [2:0] st();
        return {intf.valid, intf.led_ld_y, intf.led_ld_x};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sw(input logic [2:0] v);
        intf.sw0 = v[0];
        intf.sw1 = v[1];
        intf.sw2 = v[2];
    endtask

    // Clean press: held long enough to capture, then released long enough to settle.
    task automatic press_btn();
        intf.btn = 1'b1;
        tick(7);
        intf.btn = 1'b0;
        tick(8);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        intf.btn = 1'b0;
        set_sw(3'b000);
        #12;
        check("rst_x", xv(), 3'b000);
        check("rst_y", yv(), 3'b000);
        check("rst_status", st(), 3'b001);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // Basic entry: X = 101
        set_sw(3'b101);
        tick(3);
        intf.btn = 1'b1;
        tick(6);
        check("x_not_yet", st(), 3'b001);
        check("x_not_yet_val", xv(), 3'b000);
        tick(1);
        check("x_cap", xv(), 3'b101);
        check("x_cap_state", st(), 3'b010);
        tick(3);
        intf.btn = 1'b0;
        tick(10);

        // Y = 011
        set_sw(3'b011);
        tick(3);
        intf.btn = 1'b1;
        tick(6);
        check("y_not_yet", st(), 3'b010);
        tick(1);
        check("y_cap", yv(), 3'b011);
        check("y_cap_state", st(), 3'b100);
        check("x_hold", xv(), 3'b101);
        check("adder_sum", 32'(xv()) + 32'(yv()), 32'd8);
        intf.btn = 1'b0;
        tick(10);

        // Wrap-around with 111/111
        press_btn();
        check("wrap1_state", st(), 3'b001);
        set_sw(3'b111);
        tick(3);
        press_btn();
        press_btn();
        check("full_x", xv(), 3'b111);
        check("full_y", yv(), 3'b111);
        check("full_state", st(), 3'b100);
        press_btn();
        check("wrap_x", xv(), 3'b000);
        check("wrap_y", yv(), 3'b000);
        check("wrap_state", st(), 3'b001);

        // Bounce rejection then stable high: X = 010
        set_sw(3'b010);
        tick(3);
        intf.btn = 1'b1; tick(1);
        intf.btn = 1'b0; tick(1);
        intf.btn = 1'b1; tick(2);
        intf.btn = 1'b0; tick(1);
        intf.btn = 1'b1;
        tick(6);
        check("bounce_no_early", st(), 3'b001);
        tick(1);
        check("bounce_cap", xv(), 3'b010);
        check("bounce_state", st(), 3'b010);
        tick(10);
        check("bounce_single", st(), 3'b010);
        intf.btn = 1'b0;
        tick(10);

        // Hold 100 / release 100: one advance only
        set_sw(3'b110);
        tick(3);
        intf.btn = 1'b1;
        tick(100);
        check("hold_y", yv(), 3'b110);
        check("hold_state", st(), 3'b100);
        intf.btn = 1'b0;
        tick(100);
        check("release_state", st(), 3'b100);
        check("release_y", yv(), 3'b110);

        // Switch toggling without a press changes nothing
        for (int i = 0; i < 20; i++) begin
            set_sw(3'(i));
            tick(1);
        end
        check("swtog_x", xv(), 3'b010);
        check("swtog_y", yv(), 3'b110);
        check("swtog_state", st(), 3'b100);
        press_btn();
        check("wrap2_state", st(), 3'b001);

        // Late switch change one cycle before the capture edge is not seen
        set_sw(3'b001);
        intf.btn = 1'b1;
        tick(5);
        set_sw(3'b100);
        tick(1);
        check("late_not_yet", st(), 3'b001);
        tick(1);
        check("late_sw_x", xv(), 3'b001);
        intf.btn = 1'b0;
        tick(10);

        // Mid-operation reset with button held, partial debounce discarded
        set_sw(3'b111);
        intf.btn = 1'b1;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_x", xv(), 3'b000);
        check("midrst_state", st(), 3'b001);
        tick(3);
        rst_n = 1'b1;
        tick(6);
        check("post_rst_no_early", xv(), 3'b000);
        check("post_rst_no_early_st", st(), 3'b001);
        tick(1);
        check("post_rst_cap", xv(), 3'b111);
        check("post_rst_state", st(), 3'b010);
        intf.btn = 1'b0;
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
